spi_rom_reader: RTL



---
 rtl/spi_rom_reader.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_rom_reader.sv
// spi_rom_reader: SPI mode-0 master that streams bytes from an M95xxx EEPROM
// using the READ (0x03) command and hands them out over a valid/ready port.
module spi_rom_reader #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 16,
  parameter int LEN_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic [7:0]        data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              done,
  output logic              busy,
  output logic              spi_clk_out,
  output logic              mosi_out,
  output logic              spi_en_out,
  input  logic              miso
);
  localparam int SW = 8 + ADDR_W;
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(SW);
  localparam logic [DW-1:0]    HALF_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]    GAP_LAST  = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0]    DIV_ONE   = DW'(1);
  localparam logic [BW-1:0]    BIT_ONE   = BW'(1);
  localparam logic [BW-1:0]    BYTE_LAST = BW'(7);
  localparam logic [BW-1:0]    TX_LAST   = BW'(SW - 1);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [7:0]       READ_CMD  = 8'h03;

  typedef enum logic [3:0] {
    IDLE, CS_SETUP, CMD, ADDR, DATA, STALL, CS_HOLD, CS_GAP, FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [SW-1:0]     shift_q, shift_d;
  logic [7:0]        rx_q, rx_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              sck_q, sck_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic [7:0]        dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              rdy_q, rdy_d;

  logic              out_free;
  logic              half_end;
  logic [DW-1:0]     div_inc;
  logic [7:0]        rx_byte;

  // The output register can take a byte if empty or being drained this cycle.
  assign out_free = !dvalid_q || data_ready;
  assign half_end = (div_q == HALF_LAST);
  assign div_inc  = div_q + DIV_ONE;
  assign rx_byte  = {rx_q[6:0], miso};

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    sck_d    = sck_q;
    cs_d     = cs_q;
    mosi_d   = mosi_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    rdy_d    = rdy_q;

    if (dvalid_q && data_ready) dvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && rdy_q) begin
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
          cnt_d   = req_len;
          shift_d = {READ_CMD, req_addr};
          div_d   = '0;
          bit_d   = '0;
          if (req_len != '0) begin
            state_d = CS_SETUP;
            cs_d    = 1'b0;
            mosi_d  = READ_CMD[7];
          end else begin
            state_d = FINISH;
          end
        end
      end
      CS_SETUP: begin
        if (half_end) begin
          sck_d   = 1'b1;
          div_d   = '0;
          state_d = CMD;
        end else begin
          div_d = div_inc;
        end
      end
      // Command and address share one shift register; bits advance on SCK fall.
      CMD, ADDR: begin
        if (!half_end) begin
          div_d = div_inc;
        end else begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d   = 1'b0;
            shift_d = shift_q << 1;
            mosi_d  = shift_q[SW-2];
            bit_d   = bit_q + BIT_ONE;
            if (bit_q == BYTE_LAST) state_d = ADDR;
            if (bit_q == TX_LAST) begin
              mosi_d  = 1'b0;
              bit_d   = '0;
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (!half_end) begin
          div_d = div_inc;
        end else begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            rx_d  = rx_byte;
            bit_d = bit_q + BIT_ONE;
            if (bit_q == BYTE_LAST) begin
              bit_d = '0;
              if (out_free) begin
                dout_d   = rx_byte;
                dvalid_d = 1'b1;
                cnt_d    = cnt_q - LEN_ONE;
              end else begin
                state_d = STALL;
              end
            end
          end else begin
            sck_d = 1'b0;
            if (cnt_q == '0) state_d = CS_HOLD;
          end
        end
      end
      // Finish the current high phase, then park SCK low until the byte can go out.
      STALL: begin
        if (sck_q) begin
          if (half_end) begin
            sck_d = 1'b0;
            div_d = '0;
          end else begin
            div_d = div_inc;
          end
        end else if (out_free) begin
          dout_d   = rx_q;
          dvalid_d = 1'b1;
          cnt_d    = cnt_q - LEN_ONE;
          div_d    = '0;
          state_d  = (cnt_q == LEN_ONE) ? CS_HOLD : DATA;
        end
      end
      CS_HOLD: begin
        if (half_end) begin
          cs_d    = 1'b1;
          div_d   = '0;
          state_d = CS_GAP;
        end else begin
          div_d = div_inc;
        end
      end
      CS_GAP: begin
        if (div_q == GAP_LAST) begin
          div_d   = '0;
          state_d = FINISH;
        end else begin
          div_d = div_inc;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      sck_q    <= 1'b0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      sck_q    <= sck_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
    end
  end

  assign spi_clk_out = sck_q;
  assign spi_en_out  = cs_q;
  assign mosi_out    = mosi_q;
  assign data_out    = dout_q;
  assign data_valid  = dvalid_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign req_ready   = rdy_q;

endmodule
